// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing/pattern generator.
//   mode_e     : run-time source select (grid, colour bars, solid, stream)
//   rgb_t      : 24-bit {R,G,B} pixel
//   BAR_COLORS : colour of each of the eight bars, left to right
//   DEF_*      : default 800x480 timing
package vga_pkg;

  typedef enum logic [1:0] {MODE_GRID, MODE_BARS, MODE_SOLID, MODE_STREAM} mode_e;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BAR_COLORS [8] = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

endpackage

// File: rtl/video_if.sv
// Video output bundle towards the DAC / HDMI encoder.
//   CLK   : pixel clock
//   HS/VS : sync levels (polarity set by the driver's parameters)
//   BLANK : 1 during active video (blank_n semantics)
//   RGB   : {R,G,B} pixel, 0 outside active video
interface video_if;
  import vga_pkg::*;

  logic CLK;
  logic HS;
  logic VS;
  logic BLANK;
  rgb_t RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters and region decode.
// Each line (and each frame, in lines) runs: front porch, sync pulse,
// back porch, active.
//   pixel_clk, pixel_rst : clock, asynchronous active-high reset
//   x, y                 : active-area coordinates (valid while active)
//   h_active, active     : horizontal-active, and full active-video flag
//   frame_first          : counter is at h=0, v=0
//   frame_last           : counter is at the last pixel of the frame
//   hs_lvl, vs_lvl       : sync levels for the current counter value
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int   HDISP  = DEF_HDISP,
  parameter int   VDISP  = DEF_VDISP,
  parameter int   HFP    = DEF_HFP,
  parameter int   HPULSE = DEF_HPULSE,
  parameter int   HBP    = DEF_HBP,
  parameter int   VFP    = DEF_VFP,
  parameter int   VPULSE = DEF_VPULSE,
  parameter int   VBP    = DEF_VBP,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  localparam int  HTOTAL = HFP + HPULSE + HBP + HDISP,
  localparam int  VTOTAL = VFP + VPULSE + VBP + VDISP,
  localparam int  HW     = $clog2(HTOTAL),
  localparam int  VW     = $clog2(VTOTAL)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          h_active,
  output logic          active,
  output logic          frame_first,
  output logic          frame_last,
  output logic          hs_lvl,
  output logic          vs_lvl
);

  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last, v_last, h_pulse, v_pulse, v_active;

  assign h_last = (h == HW'(HTOTAL - 1));
  assign v_last = (v == VW'(VTOTAL - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign h_pulse  = (h >= HW'(HFP)) && (h < HW'(HFP + HPULSE));
  assign v_pulse  = (v >= VW'(VFP)) && (v < VW'(VFP + VPULSE));
  assign h_active = (h >= HW'(HSTART));
  assign v_active = (v >= VW'(VSTART));
  assign active   = h_active && v_active;

  assign x = h - HW'(HSTART);
  assign y = v - VW'(VSTART);

  assign hs_lvl = h_pulse ? HS_POL : ~HS_POL;
  assign vs_lvl = v_pulse ? VS_POL : ~VS_POL;

  assign frame_first = (h == '0) && (v == '0);
  assign frame_last  = h_last && v_last;

endmodule

// File: rtl/vga_timing_pattern.sv
// Parametrised VGA timing generator with selectable pixel source.
//   pixel_clk, pixel_rst : pixel clock, asynchronous active-high reset
//   mode                 : 0 grid, 1 colour bars, 2 solid, 3 stream;
//                          taken only at the last pixel of a frame
//   solid_rgb            : colour for solid mode
//   pix_data/pix_valid/pix_ready : pixel stream, accepted on valid&&ready
//   frame_start          : one-cycle pulse aligned with the first output
//                          pixel of each frame
//   underflow            : sticky, stream starved during the current frame
//   underflow_cnt        : starved pixels in the previous frame (only when
//                          VGA_UNDERFLOW_CNT_EN is defined)
//   video_ifm            : HS/VS/BLANK/RGB, all registered from the same
//                          counter value so they stay mutually aligned
module vga_timing_pattern
  import vga_pkg::*;
#(
  parameter int   HDISP     = DEF_HDISP,
  parameter int   VDISP     = DEF_VDISP,
  parameter int   HFP       = DEF_HFP,
  parameter int   HPULSE    = DEF_HPULSE,
  parameter int   HBP       = DEF_HBP,
  parameter int   VFP       = DEF_VFP,
  parameter int   VPULSE    = DEF_VPULSE,
  parameter int   VBP       = DEF_VBP,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   GRID_STEP = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  rgb_t        solid_rgb,
  input  rgb_t        pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
`ifdef VGA_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt,
`endif
  video_if.master     video_ifm
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int BAR_W  = HDISP / 8;

  // GRID_STEP is a power of two, so "coordinate mod step == 0" is a mask test.
  localparam logic [HW-1:0] X_MASK = HW'(GRID_STEP - 1);
  localparam logic [VW-1:0] Y_MASK = VW'(GRID_STEP - 1);

  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          h_active, active, frame_first, frame_last, hs_lvl, vs_lvl;

  vga_sync_counter #(
    .HDISP (HDISP), .VDISP (VDISP),
    .HFP   (HFP),   .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),   .VPULSE(VPULSE), .VBP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_sync (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .x          (x),
    .y          (y),
    .h_active   (h_active),
    .active     (active),
    .frame_first(frame_first),
    .frame_last (frame_last),
    .hs_lvl     (hs_lvl),
    .vs_lvl     (vs_lvl)
  );

  mode_e mode_q;

  // Mode changes only between frames so a switch never tears an image.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst)       mode_q <= MODE_GRID;
    else if (frame_last) mode_q <= mode_e'(mode);
  end

  // Bar tracking: bar_pos walks 0..BAR_W-1 inside a bar and bar_idx steps
  // once per bar; both restart during horizontal blanking. bar_idx parks at 8
  // so leftover pixels beyond the eighth bar come out black.
  logic [HW-1:0] bar_pos;
  logic [3:0]    bar_idx;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!h_active) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_idx != 4'd8) begin
      if (bar_pos == HW'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 4'd1;
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end
    end
  end

  logic starve;
  rgb_t pattern;

  assign pix_ready = active && (mode_q == MODE_STREAM);
  assign starve    = pix_ready && !pix_valid;

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    pattern = '0;
    if (active) begin
      unique case (mode_q)
        MODE_GRID:   pattern = (((x & X_MASK) == '0) || ((y & Y_MASK) == '0)) ?
                               24'hFFFFFF : 24'h000000;
        MODE_BARS:   pattern = bar_idx[3] ? 24'h000000 : BAR_COLORS[bar_idx[2:0]];
        MODE_SOLID:  pattern = solid_rgb;
        MODE_STREAM: pattern = pix_valid ? pix_data : 24'h000000;
        default:     pattern = '0;
      endcase
    end
  end

  logic hs_q, vs_q, blank_q;
  rgb_t rgb_q;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      hs_q        <= hs_lvl;
      vs_q        <= vs_lvl;
      blank_q     <= active;
      rgb_q       <= pattern;
      frame_start <= frame_first;
      // A starved pixel on the frame's first cycle outranks the clear.
      if (starve)           underflow <= 1'b1;
      else if (frame_first) underflow <= 1'b0;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] starve_cnt;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      starve_cnt    <= '0;
      underflow_cnt <= '0;
    end else if (frame_first) begin
      underflow_cnt <= starve_cnt;
      starve_cnt    <= {15'd0, starve};
    end else if (starve && (starve_cnt != 16'hFFFF)) begin
      starve_cnt    <= starve_cnt + 16'd1;
    end
  end
`endif

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;

endmodule

// File: doc/vga_timing_pattern.md
Name: vga_timing_pattern

Overview:
Parametrised successor to the team's fixed 800x480 VGA generator. It produces HS/VS/BLANK/RGB on video_if from run-time-selectable sources: grid, colour bars, solid colour, or a pixel stream from the framebuffer reader.
- All timing values and sync polarities are parameters.
- A valid/ready stream port feeds pixels during active video; underflow is detected.
- The block sits between the framebuffer/FIFO and the video DAC/HDMI encoder in the pixel_clk domain.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width (pixels)
HBP, 40, horizontal back porch (pixels)
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width (lines)
VBP, 29, vertical back porch (lines)
HS_POL, 0, HS level during pulse (0 = active-low)
VS_POL, 0, VS level during pulse
GRID_STEP, 16, grid spacing in pixels; power of two, at least 2

Ports:
pixel_clk  in  1  pixel clock
pixel_rst  in  1  asynchronous, active-high reset
mode  in  2  source select: 0 grid, 1 bars, 2 solid, 3 stream
solid_rgb  in  24  colour for mode 2, {R,G,B}
pix_data  in  24  stream pixel
pix_valid  in  1  stream pixel valid
pix_ready  out  1  stream pixel accepted this cycle when valid&&ready
frame_start  out  1  one-cycle pulse at h=0,v=0
underflow  out  1  sticky: stream starved during current frame
video_ifm  if  -  video_if.master: CLK, HS, VS, BLANK, RGB[23:0]

Behaviour:
- Timing constants: HTOTAL=HFP+HPULSE+HBP+HDISP, VTOTAL=VFP+VPULSE+VBP+VDISP.
- Counter widths: h width = $clog2(HTOTAL), v width = $clog2(VTOTAL).
- Horizontal counter h counts 0..HTOTAL-1, then wraps to 0.
- Vertical counter v increments only when h wraps, counts 0..VTOTAL-1, then wraps to 0.
- Region order per line: FP [0,HFP), pulse [HFP,HFP+HPULSE), BP, then active [HFP+HPULSE+HBP, HTOTAL). Vertical region order is identical.
- active = h_active && v_active. Pixel coordinates: x = h-(HFP+HPULSE+HBP), y = v-(VFP+VPULSE+VBP).
- video_ifm.CLK = pixel_clk, combinational.
- HS, VS, BLANK and RGB are registered with 1-cycle latency from counter state. All four come from the same counter value, so they are mutually aligned.
- HS = HS_POL during the horizontal pulse, otherwise ~HS_POL. VS is defined the same way using VS_POL.
- BLANK = 1 during active, 0 otherwise (blank_n semantics).
- RGB = 0 whenever not active.
- mode is sampled into mode_q only when h=HTOTAL-1 and v=VTOTAL-1, so switching never tears a frame. Reset value of mode_q = 0 (grid).
- Grid (mode 0): RGB = 24'hFFFFFF when x%GRID_STEP==0 or y%GRID_STEP==0, else 0. Use bit masks, no divider.
- Bars (mode 1): 8 bars of width HDISP/8, ordered white, yellow, cyan, green, magenta, red, blue, black (8-bit channels 0xFF/0x00). Pixels beyond 8*(HDISP/8) are black. Implemented with a bar counter, no divider.
- Solid (mode 2): RGB = solid_rgb, sampled in the same cycle.
- Stream (mode 3):
  - pix_ready = active && mode_q==3, combinational from counters.
  - On valid&&ready, RGB <= pix_data.
  - If ready && !valid: RGB <= 0 and underflow is set.
  - pix_ready = 0 in every other mode.
- underflow is cleared on the frame_start cycle. A starvation event in that same cycle wins over the clear.
- frame_start is registered, aligned with the first FP pixel output of the frame.
- Reset values: h=0, v=0, mode_q=0, HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, frame_start=0, underflow=0.
- Reset mid-frame restarts at h=0, v=0. First frame_start is output 1 cycle after reset release.

Optional Feature:
VGA_UNDERFLOW_CNT_EN
- Defined: adds output underflow_cnt[15:0], the number of starved pixels in the previous frame.
  - Internal counter saturates at 16'hFFFF.
  - At frame_start it is copied to underflow_cnt and the internal counter is cleared.
  - underflow_cnt reset value = 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - typedef enum logic [1:0] {MODE_GRID, MODE_BARS, MODE_SOLID, MODE_STREAM};
  - typedef logic [23:0] rgb_t;
  - the 8-entry bar colour constant array;
  - default 800x480 timing localparams.
- Sub-module vga_sync_counter (same parameters) owns h/v counters, region decode, active, x/y and the sync levels. The top level adds the pattern mux, stream handshake and output registers.

Test Plan:
Bench parameters: HDISP=16, VDISP=8, HFP=2, HPULSE=3, HBP=2, VFP=1, VPULSE=2, VBP=1, GRID_STEP=4; HTOTAL=23, VTOTAL=12.
1. Reset then run 2 frames:
   - HS low for 3 cycles of every 23; VS low for 2 lines (46 cycles) of every 276.
   - BLANK high 16 cycles/line on 8 lines; frame_start period 276.
2. Mode 0: active line y=1 gives RGB FFFFFF at x=0,4,8,12 and 0 elsewhere; line y=4 is all FFFFFF.
3. Mode 1: x=0..1 FFFFFF, x=2..3 FFFF00, …, x=14..15 000000.
4. Mode 3 with pix_valid=1 and incrementing data:
   - exactly 128 accepts per frame; RGB equals data 1 cycle after acceptance; underflow stays 0.
   - Drop valid for 1 active cycle: RGB=0 at that pixel; underflow set until next frame_start.
5. Switch mode 0→2 mid-frame with solid_rgb=123456: no change until the next frame; next frame all active pixels = 123456.
6. Assert pixel_rst mid-line: all outputs return to reset values immediately; after release, timing restarts from h=0, v=0 (first frame_start 1 cycle later).
